smu_mp_sram_ctrl: RTL and testbench



---
 rtl/smu_pkg.sv | 64 ++++++
 rtl/smu_sram_chan.sv | 162 ++++++++++++++++
 rtl/smu_mp_sram_ctrl.sv | 64 ++++++
 tb/tb_smu_mp_sram_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smu_pkg.sv
// smu_pkg: shared AHB constants, channel FSM states, request/response
// structs and the byte-lane decode used by the multi-port SRAM controller.
package smu_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_DATA,
    ST_RD_WAIT,
    ST_WR_DATA,
    ST_ERR1,
    ST_ERR2
  } smu_state_e;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] wdata;
  } ahb_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic [1:0]  resp;
  } ahb_rsp_t;

  // NONSEQ/SEQ carry a transfer; IDLE/BUSY do not
  function automatic logic trans_active(input logic [1:0] trans);
    case (trans)
      HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      default:                   trans_active = 1'b0;
    endcase
  endfunction

  // little-endian byte lanes touched by a transfer
  function automatic logic [3:0] lane_decode(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    lane_decode = 4'b0001 << a;
      3'd1:    lane_decode = a[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_decode = 4'b1111;
      default: lane_decode = 4'b0000;
    endcase
  endfunction

  // oversize or misaligned transfer
  function automatic logic align_err(input logic [2:0] size, input logic [1:0] a);
    align_err = (size > 3'd2) ||
                ((size == 3'd1) && a[0]) ||
                ((size == 3'd2) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/smu_sram_chan.sv
// smu_sram_chan: one AHB-Lite slave channel driving one single-port SRAM
// bank, with a posted-write buffer and read-after-write byte merge.
// Optional macro SMU_PROT_EN: user writes to the low 256 words error out.
module smu_sram_chan
  import smu_pkg::*;
#(
  parameter int BANK_AW = 13,
  parameter int RD_WAIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  ahb_req_t           req,
  output ahb_rsp_t           rsp,
  output logic               cen,
  output logic [3:0]         wen,
  output logic [BANK_AW-1:0] addr,
  output logic [31:0]        wdata,
  input  logic [31:0]        rdata,
  output logic               idle
);

  smu_state_e         state;
  logic [1:0]         wcnt;
  logic [BANK_AW-1:0] wr_addr, buf_addr;
  logic [3:0]         wr_lanes, buf_lanes, mrg_lanes;
  logic [31:0]        buf_data, mrg_data, rd_q, rd_mrg;
  logic               buf_valid, mrg_en;

  logic               ready, accept, bad, rd_issue, wr_acc, direct, hit;
  logic [BANK_AW-1:0] waddr;
  logic [3:0]         lanes;
  logic               unused;

  assign waddr  = req.addr[BANK_AW+1:2];
  assign lanes  = lane_decode(req.size, req.addr[1:0]);
  assign unused = ^{req.prot, req.addr[31:BANK_AW+2]};

  // hready as a decode of the channel state
  always_comb begin
    case (state)
      ST_RD_DATA: ready = (RD_WAIT == 0);
      ST_RD_WAIT: ready = (wcnt == 2'(RD_WAIT));
      ST_ERR1:    ready = 1'b0;
      default:    ready = 1'b1;
    endcase
  end

  // transfers that must be answered with ERROR instead of touching the bank
  always_comb begin
    bad = align_err(req.size, req.addr[1:0]);
`ifdef SMU_PROT_EN
    if (req.write && !req.prot[1] && ((waddr >> 8) == '0)) bad = 1'b1;
`endif
  end

  // rst_n gating keeps the SRAM quiet while reset is held
  assign accept   = rst_n && req.sel && trans_active(req.trans) && ready;
  assign rd_issue = accept && !req.write && !bad;
  assign wr_acc   = accept && req.write && !bad;
  // back-to-back writes: the in-flight data goes straight to the bank so the
  // buffer never holds a word when the next write data phase starts
  assign direct   = (state == ST_WR_DATA) && wr_acc;
  assign hit      = ((state == ST_WR_DATA) && (waddr == wr_addr)) ||
                    (buf_valid && (waddr == buf_addr));

  // SRAM port: reads win, then direct writes, then buffer drain
  always_comb begin
    cen   = 1'b1;
    wen   = 4'hF;
    addr  = '0;
    wdata = '0;
    if (rd_issue) begin
      cen  = 1'b0;
      addr = waddr;
    end else if (direct) begin
      cen   = 1'b0;
      wen   = ~wr_lanes;
      addr  = wr_addr;
      wdata = req.wdata;
    end else if (buf_valid) begin
      cen   = 1'b0;
      wen   = ~buf_lanes;
      addr  = buf_addr;
      wdata = buf_data;
    end
  end

  // overlay buffered lanes on the SRAM word
  always_comb begin
    rd_mrg = rdata;
    for (int i = 0; i < 4; i++)
      if (mrg_en && mrg_lanes[i]) rd_mrg[i*8 +: 8] = mrg_data[i*8 +: 8];
  end

  // AHB response and idle flag
  always_comb begin
    rsp.rdata = (state == ST_RD_DATA) ? rd_mrg : rd_q;
    rsp.ready = ready;
    rsp.resp  = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    idle      = (state == ST_IDLE) && !buf_valid && !accept;
  end

  // channel FSM; a completing cycle may accept the next address phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else if (ready) begin
      wcnt <= '0;
      if (!accept)        state <= ST_IDLE;
      else if (bad)       state <= ST_ERR1;
      else if (req.write) state <= ST_WR_DATA;
      else                state <= ST_RD_DATA;
    end else begin
      case (state)
        ST_RD_DATA: begin
          state <= ST_RD_WAIT;
          wcnt  <= 2'd1;
        end
        ST_RD_WAIT: wcnt  <= wcnt + 2'd1;
        ST_ERR1:    state <= ST_ERR2;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // write latch, posted buffer, merge snapshot and read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr   <= '0;
      wr_lanes  <= '0;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_lanes <= '0;
      buf_data  <= '0;
      mrg_en    <= 1'b0;
      mrg_lanes <= '0;
      mrg_data  <= '0;
      rd_q      <= '0;
    end else begin
      if (wr_acc) begin
        wr_addr  <= waddr;
        wr_lanes <= lanes;
      end
      if ((state == ST_WR_DATA) && !direct) begin
        buf_valid <= 1'b1;
        buf_addr  <= wr_addr;
        buf_lanes <= wr_lanes;
        buf_data  <= req.wdata;
      end else if (buf_valid && !rd_issue) begin
        buf_valid <= 1'b0;
      end
      if (rd_issue) begin
        mrg_en    <= hit;
        mrg_lanes <= (state == ST_WR_DATA) ? wr_lanes : buf_lanes;
        mrg_data  <= (state == ST_WR_DATA) ? req.wdata : buf_data;
      end
      if (state == ST_RD_DATA) rd_q <= rd_mrg;
    end
  end

endmodule

// File: rtl/smu_mp_sram_ctrl.sv
// smu_mp_sram_ctrl: NUM_PORTS independent AHB-Lite channels, each owning
// one 32-bit single-port SRAM bank. Optional macro SMU_PROT_EN (see
// smu_sram_chan) adds write protection of the low 1 KB of each bank.
module smu_mp_sram_ctrl
  import smu_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int BANK_AW   = 13,
  parameter int RD_WAIT   = 0
) (
  input  logic                         pmu_smc_hclk,
  input  logic                         pmu_smc_hrst_b,
  input  logic [NUM_PORTS-1:0]         hmain0_smu_hsel,
  input  logic [NUM_PORTS*32-1:0]      hmain0_smu_haddr,
  input  logic [NUM_PORTS*2-1:0]       hmain0_smu_htrans,
  input  logic [NUM_PORTS-1:0]         hmain0_smu_hwrite,
  input  logic [NUM_PORTS*3-1:0]       hmain0_smu_hsize,
  input  logic [NUM_PORTS*4-1:0]       hmain0_smu_hprot,
  input  logic [NUM_PORTS*32-1:0]      hmain0_smu_hwdata,
  output logic [NUM_PORTS*32-1:0]      smu_hmain0_hrdata,
  output logic [NUM_PORTS-1:0]         smu_hmain0_hready,
  output logic [NUM_PORTS*2-1:0]       smu_hmain0_hresp,
  output logic [NUM_PORTS-1:0]         smu_sram_cen,
  output logic [NUM_PORTS*4-1:0]       smu_sram_wen,
  output logic [NUM_PORTS*BANK_AW-1:0] smu_sram_addr,
  output logic [NUM_PORTS*32-1:0]      smu_sram_wdata,
  input  logic [NUM_PORTS*32-1:0]      sram_smu_rdata,
  output logic [NUM_PORTS-1:0]         smu_idle
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chan
    ahb_req_t req;
    ahb_rsp_t rsp;

    assign req = '{sel:   hmain0_smu_hsel[p],
                   addr:  hmain0_smu_haddr[p*32 +: 32],
                   trans: hmain0_smu_htrans[p*2 +: 2],
                   write: hmain0_smu_hwrite[p],
                   size:  hmain0_smu_hsize[p*3 +: 3],
                   prot:  hmain0_smu_hprot[p*4 +: 4],
                   wdata: hmain0_smu_hwdata[p*32 +: 32]};

    assign smu_hmain0_hrdata[p*32 +: 32] = rsp.rdata;
    assign smu_hmain0_hready[p]          = rsp.ready;
    assign smu_hmain0_hresp[p*2 +: 2]    = rsp.resp;

    smu_sram_chan #(
      .BANK_AW (BANK_AW),
      .RD_WAIT (RD_WAIT)
    ) u_chan (
      .clk   (pmu_smc_hclk),
      .rst_n (pmu_smc_hrst_b),
      .req   (req),
      .rsp   (rsp),
      .cen   (smu_sram_cen[p]),
      .wen   (smu_sram_wen[p*4 +: 4]),
      .addr  (smu_sram_addr[p*BANK_AW +: BANK_AW]),
      .wdata (smu_sram_wdata[p*32 +: 32]),
      .rdata (sram_smu_rdata[p*32 +: 32]),
      .idle  (smu_idle[p])
    );
  end

endmodule

// File: tb/tb_smu_mp_sram_ctrl.sv
// tb_smu_mp_sram_ctrl: directed checks of the multi-port SRAM controller.
// Main DUT: 4 ports, RD_WAIT=0. Second DUT: 1 port, RD_WAIT=2.
module tb_smu_mp_sram_ctrl;

  localparam int NP = 4;
  localparam int AW = 13;

`ifdef SMU_PROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  localparam logic [31:0] EA [3] = '{32'h1, 32'h2, 32'h0};
  localparam logic [2:0]  ES [3] = '{3'd1, 3'd2, 3'd3};
  localparam logic        EW [3] = '{1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n;

  logic [NP-1:0]      hsel, hwrite, hready, cen, idle;
  logic [NP*32-1:0]   haddr, hwdata, hrdata, swdata, srdata;
  logic [NP*2-1:0]    htrans, hresp;
  logic [NP*3-1:0]    hsize;
  logic [NP*4-1:0]    hprot, wen;
  logic [NP*AW-1:0]   saddr;

  logic        b_hsel, b_hwrite, b_hready, b_cen, b_idle;
  logic [31:0] b_haddr, b_hwdata, b_hrdata, b_swdata, b_srdata;
  logic [1:0]  b_htrans, b_hresp;
  logic [2:0]  b_hsize;
  logic [3:0]  b_hprot, b_wen;
  logic [AW-1:0] b_saddr;

  logic [31:0] mem   [NP][1<<AW];
  logic [31:0] b_mem [1<<AW];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  smu_mp_sram_ctrl #(.NUM_PORTS(NP), .BANK_AW(AW), .RD_WAIT(0)) u_dut (
    .pmu_smc_hclk(clk), .pmu_smc_hrst_b(rst_n),
    .hmain0_smu_hsel(hsel), .hmain0_smu_haddr(haddr), .hmain0_smu_htrans(htrans),
    .hmain0_smu_hwrite(hwrite), .hmain0_smu_hsize(hsize), .hmain0_smu_hprot(hprot),
    .hmain0_smu_hwdata(hwdata), .smu_hmain0_hrdata(hrdata), .smu_hmain0_hready(hready),
    .smu_hmain0_hresp(hresp), .smu_sram_cen(cen), .smu_sram_wen(wen),
    .smu_sram_addr(saddr), .smu_sram_wdata(swdata), .sram_smu_rdata(srdata),
    .smu_idle(idle));

  smu_mp_sram_ctrl #(.NUM_PORTS(1), .BANK_AW(AW), .RD_WAIT(2)) u_dut2 (
    .pmu_smc_hclk(clk), .pmu_smc_hrst_b(rst_n),
    .hmain0_smu_hsel(b_hsel), .hmain0_smu_haddr(b_haddr), .hmain0_smu_htrans(b_htrans),
    .hmain0_smu_hwrite(b_hwrite), .hmain0_smu_hsize(b_hsize), .hmain0_smu_hprot(b_hprot),
    .hmain0_smu_hwdata(b_hwdata), .smu_hmain0_hrdata(b_hrdata), .smu_hmain0_hready(b_hready),
    .smu_hmain0_hresp(b_hresp), .smu_sram_cen(b_cen), .smu_sram_wen(b_wen),
    .smu_sram_addr(b_saddr), .smu_sram_wdata(b_swdata), .sram_smu_rdata(b_srdata),
    .smu_idle(b_idle));

  // SRAM bank models: read data one cycle after cen low, byte writes
  always @(posedge clk)
    for (int c = 0; c < NP; c++)
      if (!cen[c]) begin
        if (wen[c*4 +: 4] == 4'hF) srdata[c*32 +: 32] <= mem[c][saddr[c*AW +: AW]];
        else
          for (int b = 0; b < 4; b++)
            if (!wen[c*4+b]) mem[c][saddr[c*AW +: AW]][b*8 +: 8] <= swdata[c*32+b*8 +: 8];
      end

  always @(posedge clk)
    if (!b_cen) begin
      if (b_wen == 4'hF) b_srdata <= b_mem[b_saddr];
      else
        for (int b = 0; b < 4; b++)
          if (!b_wen[b]) b_mem[b_saddr][b*8 +: 8] <= b_swdata[b*8 +: 8];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int c, input logic sel, input logic [31:0] a, input logic wr,
                     input logic [2:0] sz, input logic [3:0] pr);
    hsel[c]          = sel;
    haddr[c*32 +: 32] = a;
    htrans[c*2 +: 2] = sel ? 2'b10 : 2'b00;
    hwrite[c]        = wr;
    hsize[c*3 +: 3]  = sz;
    hprot[c*4 +: 4]  = pr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    hsel = '0; haddr = '0; htrans = '0; hwrite = '0; hsize = '0; hprot = '0; hwdata = '0;
    b_hsel = 1'b0; b_haddr = '0; b_htrans = '0; b_hwrite = 1'b0; b_hsize = '0;
    b_hprot = '0; b_hwdata = '0;
    #12;
    chk("rst_hready", 32'(hready), 32'hF);
    chk("rst_hresp", 32'(hresp), 32'h0);
    chk("rst_hrdata", hrdata[31:0] | hrdata[127:96], 32'h0);
    chk("rst_cen", 32'(cen), 32'hF);
    chk("rst_wen", 32'(wen), 32'hFFFF);
    chk("rst_addr", 32'(saddr), 32'h0);
    chk("rst_idle", 32'(idle), 32'hF);
    cyc(); rst_n = 1'b1;

    // word write, then idle: drain one cycle after the data phase
    cyc(); drv(0, 1, 32'h10, 1, 2, 4'h3); #1;
    chk("w1_aphase_cen", 32'(cen[0]), 32'h1);
    chk("w1_aphase_idle", 32'(idle[0]), 32'h0);
    cyc(); drv(0, 0, 0, 0, 0, 0); hwdata[31:0] = 32'hA5A51234; #1;
    chk("w1_dphase_hready", 32'(hready[0]), 32'h1);
    chk("w1_dphase_cen", 32'(cen[0]), 32'h1);
    cyc(); #1;
    chk("w1_drain_cen", 32'(cen[0]), 32'h0);
    chk("w1_drain_wen", 32'(wen[3:0]), 32'h0);
    chk("w1_drain_addr", 32'(saddr[AW-1:0]), 32'h4);
    chk("w1_drain_wdata", swdata[31:0], 32'hA5A51234);
    chk("w1_drain_idle", 32'(idle[0]), 32'h0);
    cyc(); #1;
    chk("w1_after_idle", 32'(idle[0]), 32'h1);
    chk("w1_after_cen", 32'(cen[0]), 32'h1);

    // byte write 0x13 then word read 0x10: merge lane 3
    cyc(); drv(0, 1, 32'h13, 1, 0, 4'h3); #1;
    cyc(); drv(0, 1, 32'h10, 0, 2, 4'h3); hwdata[31:0] = 32'h77000000; #1;
    chk("raw_rd_cen", 32'(cen[0]), 32'h0);
    chk("raw_rd_wen", 32'(wen[3:0]), 32'hF);
    chk("raw_rd_addr", 32'(saddr[AW-1:0]), 32'h4);
    cyc(); drv(0, 0, 0, 0, 0, 0); #1;
    chk("raw_hready", 32'(hready[0]), 32'h1);
    chk("raw_hrdata", hrdata[31:0], 32'h77A51234);
    chk("raw_drain_cen", 32'(cen[0]), 32'h0);
    chk("raw_drain_wen", 32'(wen[3:0]), 32'h7);
    chk("raw_drain_wdata", swdata[31:0], 32'h77000000);
    cyc(); #1;
    chk("raw_after_idle", 32'(idle[0]), 32'h1);
    chk("raw_mem", mem[0][4], 32'h77A51234);

    // back-to-back writes, then pipelined reads
    cyc(); drv(0, 1, 32'h50, 1, 2, 4'h3); #1;
    cyc(); drv(0, 1, 32'h54, 1, 2, 4'h3); hwdata[31:0] = 32'h01010101; #1;
    chk("b2b_direct_cen", 32'(cen[0]), 32'h0);
    chk("b2b_direct_wen", 32'(wen[3:0]), 32'h0);
    chk("b2b_direct_addr", 32'(saddr[AW-1:0]), 32'h14);
    chk("b2b_direct_wdata", swdata[31:0], 32'h01010101);
    cyc(); drv(0, 0, 0, 0, 0, 0); hwdata[31:0] = 32'h02020202; #1;
    chk("b2b_dphase_cen", 32'(cen[0]), 32'h1);
    cyc(); #1;
    chk("b2b_drain_addr", 32'(saddr[AW-1:0]), 32'h15);
    chk("b2b_drain_wdata", swdata[31:0], 32'h02020202);
    cyc(); drv(0, 1, 32'h50, 0, 2, 4'h3); #1;
    cyc(); drv(0, 1, 32'h54, 0, 2, 4'h3); #1;
    chk("b2b_rd0", hrdata[31:0], 32'h01010101);
    cyc(); drv(0, 0, 0, 0, 0, 0); #1;
    chk("b2b_rd1", hrdata[31:0], 32'h02020202);

    // error responses: two cycles, no SRAM access
    for (int i = 0; i < 3; i++) begin
      cyc(); drv(0, 1, EA[i], EW[i], ES[i], 4'h3); #1;
      chk("err_aphase_cen", 32'(cen[0]), 32'h1);
      cyc(); drv(0, 0, 0, 0, 0, 0); #1;
      chk("err1_hready", 32'(hready[0]), 32'h0);
      chk("err1_hresp", 32'(hresp[1:0]), 32'h1);
      chk("err1_cen", 32'(cen[0]), 32'h1);
      cyc(); #1;
      chk("err2_hready", 32'(hready[0]), 32'h1);
      chk("err2_hresp", 32'(hresp[1:0]), 32'h1);
      chk("err2_cen", 32'(cen[0]), 32'h1);
      cyc(); #1;
      chk("err_done_hresp", 32'(hresp[1:0]), 32'h0);
      chk("err_done_idle", 32'(idle[0]), 32'h1);
    end

    // channels 0 and 3 write the same bank address concurrently
    cyc(); drv(0, 1, 32'h40, 1, 2, 4'h3); drv(3, 1, 32'h40, 1, 2, 4'h3); #1;
    cyc(); drv(0, 0, 0, 0, 0, 0); drv(3, 0, 0, 0, 0, 0);
    hwdata[31:0] = 32'h11111111; hwdata[127:96] = 32'h33333333; #1;
    cyc(); #1;
    chk("par_cen", 32'(cen), 32'h6);
    chk("par_addr3", 32'(saddr[3*AW +: AW]), 32'h10);
    chk("par_wdata0", swdata[31:0], 32'h11111111);
    chk("par_wdata3", swdata[127:96], 32'h33333333);
    cyc(); #1;
    chk("par_mem0", mem[0][16], 32'h11111111);
    chk("par_mem3", mem[3][16], 32'h33333333);

    // reset while channel 1 holds a buffered write
    cyc(); drv(1, 1, 32'h80, 1, 2, 4'h3); #1;
    cyc(); drv(1, 0, 0, 0, 0, 0); hwdata[63:32] = 32'hCAFEF00D; #1;
    cyc(); rst_n = 1'b0; #1;
    chk("mid_rst_cen", 32'(cen[1]), 32'h1);
    chk("mid_rst_wen", 32'(wen[7:4]), 32'hF);
    chk("mid_rst_hready", 32'(hready[1]), 32'h1);
    chk("mid_rst_idle", 32'(idle[1]), 32'h1);
    chk("mid_rst_hrdata0", hrdata[31:0], 32'h0);
    cyc(); rst_n = 1'b1; #1;
    chk("post_rst_cen", 32'(cen[1]), 32'h1);
    cyc(); #1;
    chk("post_rst_cen2", 32'(cen[1]), 32'h1);
    chk("post_rst_idle", 32'(idle[1]), 32'h1);

    // RD_WAIT=2 read on the second instance
    cyc(); b_hsel = 1; b_haddr = 32'h20; b_htrans = 2'b10; b_hwrite = 1; b_hsize = 3'd2; #1;
    cyc(); b_hsel = 0; b_htrans = 2'b00; b_hwrite = 0; b_hwdata = 32'hDEADBEEF; #1;
    cyc(); #1;
    cyc(); b_hsel = 1; b_haddr = 32'h20; b_htrans = 2'b10; b_hwrite = 0; #1;
    chk("rw2_cen", 32'(b_cen), 32'h0);
    chk("rw2_addr", 32'(b_saddr), 32'h8);
    cyc(); b_hsel = 0; b_htrans = 2'b00; #1;
    chk("rw2_wait1", 32'(b_hready), 32'h0);
    cyc(); #1;
    chk("rw2_wait2", 32'(b_hready), 32'h0);
    cyc(); #1;
    chk("rw2_ready", 32'(b_hready), 32'h1);
    chk("rw2_hrdata", b_hrdata, 32'hDEADBEEF);
    cyc(); #1;
    chk("rw2_idle", 32'(b_idle), 32'h1);

    // user write to the protected low words of channel 2, then privileged
    cyc(); drv(2, 1, 32'h100, 1, 2, 4'h0); #1;
    cyc(); drv(2, 0, 0, 0, 0, 0); hwdata[95:64] = 32'hBAD0BAD0; #1;
    chk("prot_user_hready", 32'(hready[2]), 32'(!PROT));
    chk("prot_user_hresp", 32'(hresp[5:4]), 32'(PROT));
    cyc(); #1;
    chk("prot_user_cen", 32'(cen[2]), 32'(PROT));
    chk("prot_user_hresp2", 32'(hresp[5:4]), 32'(PROT));
    cyc(); drv(2, 1, 32'h100, 1, 2, 4'h2); #1;
    chk("prot_priv_aphase", 32'(hready[2]), 32'h1);
    cyc(); drv(2, 0, 0, 0, 0, 0); hwdata[95:64] = 32'h600D600D; #1;
    chk("prot_priv_hresp", 32'(hresp[5:4]), 32'h0);
    cyc(); #1;
    chk("prot_priv_cen", 32'(cen[2]), 32'h0);
    chk("prot_priv_wdata", swdata[95:64], 32'h600D600D);
    cyc(); #1;
    chk("prot_priv_mem", mem[2][64], 32'h600D600D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
